// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment display path: digit count, active-low
// segment codes and the one-cold anode helper used by the scanner and pattern sources.
package ssd_pkg;

  localparam int SSD_DIGITS = 8;

  typedef logic [6:0] seg_t;
  typedef logic [2:0] dig_t;
  typedef logic [7:0] anode_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  localparam seg_t   SEG_OFF = 7'h7F;
  localparam anode_t AN_OFF  = 8'hFF;

  localparam seg_t SEG_A = 7'b1111110;
  localparam seg_t SEG_B = 7'b1111101;
  localparam seg_t SEG_C = 7'b1111011;
  localparam seg_t SEG_D = 7'b1110111;
  localparam seg_t SEG_E = 7'b1101111;
  localparam seg_t SEG_F = 7'b1011111;
  localparam seg_t SEG_G = 7'b0111111;

  function automatic anode_t anode_onecold(input dig_t d);
    return ~(anode_t'(1) << d);
  endfunction

endpackage

// File: rtl/ssd_scan_scheduler_if.sv
// Write-port handshake and display pins of the scan scheduler, bundled so pattern
// sources and the scanner agree on one signal set.
interface ssd_scan_scheduler_if;
  import ssd_pkg::*;

  logic   req0;
  logic   req1;
  dig_t   addr0;
  dig_t   addr1;
  seg_t   data0;
  seg_t   data1;
  logic   gnt0;
  logic   gnt1;
  logic   blank;
  anode_t anodes;
  seg_t   cathodes;
  logic   frame_tick;

  modport master (
    output req0, req1, addr0, addr1, data0, data1, blank,
    input  gnt0, gnt1, anodes, cathodes, frame_tick
  );

  modport slave (
    input  req0, req1, addr0, addr1, data0, data1, blank,
    output gnt0, gnt1, anodes, cathodes, frame_tick
  );

endinterface

// File: rtl/ssd_rr_arbiter2.sv
// Two-port round-robin arbiter with a combinational grant; the port granted last
// loses the next tie.
module ssd_rr_arbiter2
  import ssd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e last_q, last_d;

  // Reset is folded into the grant so no write can be acknowledged while it is held.
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == PORT1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = PORT0;
    end else if (gnt[1]) begin
      last_d = PORT1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= PORT1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ssd_scan_scheduler.sv
// Time-multiplexed scanner for an 8-digit common-anode display: owns the segment
// frame buffer, steps one digit per 2^REFRESH_DIV cycles and arbitrates two writers.
module ssd_scan_scheduler
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  ssd_scan_scheduler_if.slave  bus
);

  logic [REFRESH_DIV-1:0] pre_q, pre_d;
  dig_t                   dig_q, dig_d;
  seg_t                   fb_q [SSD_DIGITS];
  seg_t                   fb_d [SSD_DIGITS];
  anode_t                 anodes_q, anodes_d;
  seg_t                   cathodes_q, cathodes_d;
  logic                   frame_tick_q, frame_tick_d;
  logic [1:0]             gnt;
  logic                   pre_wrap;

  ssd_rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.req1, bus.req0}),
    .gnt   (gnt)
  );

  assign bus.gnt0 = gnt[0];
  assign bus.gnt1 = gnt[1];

  assign pre_wrap = &pre_q;

  always_comb begin
    pre_d = pre_q + REFRESH_DIV'(1);
    dig_d = pre_wrap ? dig_q + 3'd1 : dig_q;
  end

  // Grants are mutually exclusive, so at most one port touches the buffer per cycle.
  always_comb begin
    fb_d = fb_q;
    if (gnt[0]) begin
      fb_d[bus.addr0] = bus.data0;
    end
    if (gnt[1]) begin
      fb_d[bus.addr1] = bus.data1;
    end
  end

  // Pins read the pre-write buffer (no bypass). The tick fires on the first cycle of
  // digit 0's dwell so that it lands on the same cycle the anodes first show 8'hFE.
  always_comb begin
    anodes_d     = bus.blank ? AN_OFF  : anode_onecold(dig_q);
    cathodes_d   = bus.blank ? SEG_OFF : fb_q[dig_q];
    frame_tick_d = (pre_q == '0) && (dig_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q        <= '0;
      dig_q        <= '0;
      anodes_q     <= AN_OFF;
      cathodes_q   <= SEG_OFF;
      frame_tick_q <= 1'b0;
      for (int i = 0; i < SSD_DIGITS; i++) begin
        fb_q[i] <= SEG_OFF;
      end
    end else begin
      pre_q        <= pre_d;
      dig_q        <= dig_d;
      anodes_q     <= anodes_d;
      cathodes_q   <= cathodes_d;
      frame_tick_q <= frame_tick_d;
      fb_q         <= fb_d;
    end
  end

  assign bus.anodes     = anodes_q;
  assign bus.cathodes   = cathodes_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
